// File: rtl/tt3_pkg.sv
// Shared types and golden tables for the 3-input truth-table
// sweep checker.
package tt3_pkg;

    localparam int N_VEC = 8;

    localparam logic [N_VEC-1:0] TT_TASK1A = 8'h32;
    localparam logic [N_VEC-1:0] TT_TASK1B = 8'h35;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt3_state_t;

endpackage

// File: rtl/tt3_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the
// function under test plus whoever requests and reads the sweep.
interface tt3_sweep_checker_if;
    import tt3_pkg::*;

    logic             start;
    logic             A;
    logic             B;
    logic             C;
    logic             P;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_VEC-1:0] observed;
    logic [N_VEC-1:0] fail_mask;
    logic [3:0]       err_count;

    modport master (
        input  start,
        input  P,
        output A,
        output B,
        output C,
        output busy,
        output done,
        output pass,
        output observed,
        output fail_mask,
        output err_count
    );

    modport slave (
        output start,
        output P,
        input  A,
        input  B,
        input  C,
        input  busy,
        input  done,
        input  pass,
        input  observed,
        input  fail_mask,
        input  err_count
    );

endinterface

// File: rtl/tt3_settle_timer.sv
// Per-vector settle counter: counts while enabled and wraps to
// zero on its terminal count, SETTLE cycles per wrap.
module tt3_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt_q;

    assign tc = (cnt_q == 4'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? 4'd0 : cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/tt3_sweep_checker.sv
// Exhaustive self-checker: walks {A,B,C} through all 8 vectors,
// samples P after a settle delay and grades it against EXPECTED.
module tt3_sweep_checker
    import tt3_pkg::*;
#(
    parameter logic [N_VEC-1:0] EXPECTED = TT_TASK1A,
    parameter int unsigned      SETTLE   = 2
) (
    input  logic                clk,
    input  logic                reset,
    tt3_sweep_checker_if.master bus
);

    tt3_state_t       state_q;
    tt3_state_t       state_d;
    logic [2:0]       vec_q;
    logic [N_VEC-1:0] observed_q;
    logic [N_VEC-1:0] fail_mask_q;
    logic [3:0]       err_count_q;
    logic             settle_tc;
    logic             launch;
    logic             mismatch;
    logic             in_settle;

    tt3_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (launch),
        .en    (in_settle),
        .tc    (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The enum literal is qualified: the SETTLE parameter hides it.
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        in_settle = 1'b0;
        mismatch  = bus.P ^ EXPECTED[vec_q];
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    launch  = 1'b1;
                    state_d = tt3_pkg::SETTLE;
                end
            end
            tt3_pkg::SETTLE: begin
                in_settle = 1'b1;
                if (settle_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = tt3_pkg::SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || launch) begin
            vec_q       <= '0;
            observed_q  <= '0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else if (state_q == SAMPLE) begin
            observed_q[vec_q]  <= bus.P;
            fail_mask_q[vec_q] <= mismatch;
            err_count_q        <= err_count_q + {3'b000, mismatch};
            if (vec_q != 3'd7) begin
                vec_q <= vec_q + 3'd1;
            end
        end
    end

    assign bus.A         = vec_q[2];
    assign bus.B         = vec_q[1];
    assign bus.C         = vec_q[0];
    assign bus.busy      = (state_q == tt3_pkg::SETTLE)
                         || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = (state_q == DONE) && (err_count_q == 4'd0);
    assign bus.observed  = observed_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_tt3_sweep_checker.sv
// Self-checking bench for tt3_sweep_checker with a table-driven
// function model and randomized sweeps.
module tb_tt3_sweep_checker;
    import tt3_pkg::*;

    localparam int          SETTLE_CYC = 2;
    localparam logic [7:0]  GOLD       = TT_TASK1A;
    localparam int          HOLD       = SETTLE_CYC + 1;
    localparam int          LAT        = 8 * HOLD + 1;

    logic clk;
    logic reset;
    logic start;
    logic [7:0] fut_table;

    int checks;
    int errors;

    int   seq_q[$];
    logic busy_all;
    logic first_done;
    int   lat;

    tt3_sweep_checker_if bus();

    assign bus.start = start;
    assign bus.P     = fut_table[{bus.A, bus.B, bus.C}];

    tt3_sweep_checker #(
        .EXPECTED (GOLD),
        .SETTLE   (SETTLE_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] outs();
        return {bus.busy, bus.done, bus.pass,
                bus.A, bus.B, bus.C,
                bus.observed, bus.fail_mask, bus.err_count};
    endfunction

    function automatic logic [22:0] results();
        return {bus.done, bus.busy, bus.pass,
                bus.observed, bus.fail_mask, bus.err_count};
    endfunction

    // Reference grading of a whole table, straight from the rules.
    function automatic logic [22:0] model(input logic [7:0] tbl);
        logic [7:0] fm;
        logic [3:0] ec;
        fm = tbl ^ GOLD;
        ec = 4'($countones(fm));
        return {1'b1, 1'b0, ec == 4'd0, tbl, fm, ec};
    endfunction

    // Positions where the recorded vector walk departs from
    // "vector v for HOLD cycles, v = 0..7".
    function automatic int seq_errs();
        int n;
        n = (seq_q.size() == 8 * HOLD) ? 0 : 1;
        for (int k = 0; k < seq_q.size() && k < 8 * HOLD; k++) begin
            if (seq_q[k] != k / HOLD) n++;
        end
        return n;
    endfunction

    task automatic do_sweep(input logic [7:0] tbl, input int poke);
        fut_table = tbl;
        seq_q.delete();
        busy_all   = 1'b1;
        first_done = 1'bx;
        lat        = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            lat = k;
            @(negedge clk);
            start = (k == poke);
            if (k == 1) first_done = bus.done;
            if (bus.done) break;
            seq_q.push_back(int'({bus.A, bus.B, bus.C}));
            busy_all &= bus.busy;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        fut_table = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 26'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h want 0",
                         i, outs());
            end
        end
    endtask

    task automatic test_stimulus_order();
        do_sweep(8'($urandom), 0);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL order_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (seq_errs() !== 0) begin
            errors++;
            $display("FAIL order_seq: %0d bad of %0d entries",
                     seq_errs(), seq_q.size());
        end
        checks++;
        if (busy_all !== 1'b1) begin
            errors++;
            $display("FAIL order_busy: got %b want 1", busy_all);
        end
    endtask

    task automatic test_match();
        logic [22:0] exp;
        do_sweep(TT_TASK1A, 0);
        exp = model(TT_TASK1A);
        checks++;
        if (results() !== exp) begin
            errors++;
            $display("FAIL match: got %h want %h", results(), exp);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({results(), bus.A, bus.B, bus.C} !== {exp, 3'b111}) begin
            errors++;
            $display("FAIL done_hold: got %h want %h",
                     {results(), bus.A, bus.B, bus.C}, {exp, 3'b111});
        end
    endtask

    task automatic test_mismatch();
        logic [22:0] exp;
        do_sweep(TT_TASK1B, 0);
        exp = {1'b1, 1'b0, 1'b0, 8'h35, 8'h07, 4'd3};
        checks++;
        if (results() !== exp) begin
            errors++;
            $display("FAIL mismatch: got %h want %h", results(), exp);
        end
    endtask

    task automatic test_restart();
        logic [22:0] exp;
        do_sweep(8'h00, 0);
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 8'h32, 4'd3};
        checks++;
        if (first_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_drop: done got %b want 0", first_done);
        end
        checks++;
        if (results() !== exp) begin
            errors++;
            $display("FAIL restart: got %h want %h", results(), exp);
        end
    endtask

    task automatic test_ignored_start();
        logic [22:0] exp;
        do_sweep(TT_TASK1A, 3 * HOLD - 2);
        exp = model(TT_TASK1A);
        checks++;
        if ({lat, seq_errs()} !== {LAT, 32'd0}) begin
            errors++;
            $display("FAIL ign_start_timing: lat %0d bad %0d want %0d 0",
                     lat, seq_errs(), LAT);
        end
        checks++;
        if (results() !== exp) begin
            errors++;
            $display("FAIL ign_start: got %h want %h", results(), exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [22:0] exp;
        fut_table = TT_TASK1B;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4 * HOLD) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.A, bus.B, bus.C} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_vec4: got %b want 1100",
                     {bus.busy, bus.A, bus.B, bus.C});
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0", outs());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %h want 0", outs());
        end
        do_sweep(TT_TASK1B, 0);
        exp = model(TT_TASK1B);
        checks++;
        if ({lat, seq_errs(), results()} !== {LAT, 32'd0, exp}) begin
            errors++;
            $display("FAIL post_reset: lat %0d res %h want %0d %h",
                     lat, results(), LAT, exp);
        end
    endtask

    task automatic test_reset_wins();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (outs() !== 26'd0) begin
            errors++;
            $display("FAIL reset_wins: got %h want 0", outs());
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_idle: busy got %b want 0",
                     bus.busy);
        end
    endtask

    task automatic test_random();
        logic [7:0]  tbl;
        logic [22:0] exp;
        for (int it = 0; it < 8; it++) begin
            tbl = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_sweep(tbl, int'($urandom_range(2, 23)));
            exp = model(tbl);
            checks++;
            if ({lat, seq_errs(), busy_all} !== {LAT, 32'd0, 1'b1}) begin
                errors++;
                $display("FAIL rand_timing %0d: lat %0d bad %0d busy %b",
                         it, lat, seq_errs(), busy_all);
            end
            checks++;
            if (results() !== exp) begin
                errors++;
                $display("FAIL rand_result %0d: got %h want %h",
                         it, results(), exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        fut_table = '0;
        test_reset();
        test_stimulus_order();
        test_match();
        test_mismatch();
        test_restart();
        test_ignored_start();
        test_mid_reset();
        test_reset_wins();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt3_sweep_checker.md
Name: tt3_sweep_checker

Overview:
- Sequential stimulus/response end of the 3-input truth-table interface (A, B, C in; single-bit result out).
- On request, drives all 8 input vectors into a combinational function block, waits a settle time, and samples the block's output.
- Compares the captured table against a parameterised expected table and reports pass/fail per vector.
- Sits on the board or bench beside the function block, as its exhaustive self-checker.

Parameters:
- EXPECTED, 8'h32, golden table; bit i = required result for vector {A,B,C} = i.
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- A  output  1  stimulus MSB (vector bit 2)
- B  output  1  stimulus bit 1
- C  output  1  stimulus LSB (vector bit 0)
- P  input  1  result from the function under test; combinational from A/B/C, so it shares the clk domain and needs no synchroniser
- busy  output  1  high while a sweep is running
- done  output  1  high while results are valid
- pass  output  1  high when done and every vector matched
- observed  output  8  captured table, bit i = P sampled for vector i
- fail_mask  output  8  bit i set when observed[i] != EXPECTED[i]
- err_count  output  4  number of set bits in fail_mask (0..8)

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on rising clk.
- Reset values: A=B=C=0, busy=0, done=0, pass=0, observed=0, fail_mask=0, err_count=0; state IDLE.
- Registers:
  - vec: 3-bit vector index; {A,B,C} is driven directly from vec.
  - cnt: 4-bit settle counter.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE.
  - Same edge clears vec, cnt, observed, fail_mask and err_count; busy=1.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1 -> SAMPLE, and cnt clears.
- SAMPLE:
  - observed[vec] <= P.
  - fail_mask[vec] <= P ^ EXPECTED[vec].
  - err_count increments when they differ.
  - If vec==7 -> DONE; otherwise vec increments and -> SETTLE.
- Per-vector timing: each vector is held exactly SETTLE+1 cycles. P is sampled on the last of those cycles.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - vec stays at 7 and A/B/C hold 1,1,1.
  - Results hold until reset or start.
- Latency: done rises 8*(SETTLE+1)+1 edges after the edge that samples start in IDLE. SETTLE=2 gives 25.
- Start handling:
  - start in DONE behaves as start in IDLE: clears results, done=0, new sweep begins.
  - start in SETTLE or SAMPLE is ignored; it does not restart and is not queued.
- Reset mid-sweep forces the reset values on that edge. No partial results survive.
- Simultaneous reset and start: reset wins.
- err_count cannot overflow: its maximum is 8, in 4 bits.
- pass is 0 whenever done=0.

Decomposition:
- Shared package tt3_pkg holds:
  - state enum tt3_state_t {IDLE, SETTLE, SAMPLE, DONE};
  - N_VEC=8;
  - golden tables TT_TASK1A=8'h32 and TT_TASK1B=8'h35, so benches and tops pick the table by name.
- One natural sub-module: tt3_settle_timer (load/clear, count, terminal-count flag for SETTLE).
- The FSM and result registers stay in the top module.

Test Plan:
- Reset: hold reset for 3 cycles, then release with start=0 -> all outputs 0, A/B/C=000, and they stay so for 20 cycles.
- Stimulus order: SETTLE=2, start pulse -> {A,B,C} steps 000..111, each value held exactly 3 cycles; busy=1 throughout; done rises on edge 25 after start.
- Matching function: EXPECTED=8'h32, DUT model = TT_TASK1A function -> observed=8'h32, fail_mask=8'h00, err_count=0, pass=1.
- Mismatching function: EXPECTED=8'h32, DUT model = TT_TASK1B function (8'h35) -> observed=8'h35, fail_mask=8'h07, err_count=3, pass=0.
- Restart from DONE: after the previous case, tie P=0 and pulse start in DONE -> done drops next cycle; a fresh sweep ends with observed=8'h00, fail_mask=8'h32, err_count=3, pass=0.
- Ignored start and mid-sweep reset: pulse start during vector 2 -> no restart, sweep timing unchanged; assert reset during vector 4 -> next cycle all outputs 0 and IDLE; a following start completes a full 8-vector sweep correctly.
